// File: rtl/acc4_seq.sv
// acc4_seq: accumulates NUM 4-bit beats (with carry-in) per group and presents
// the sum plus a sticky carry flag. Define ACC4_SAT_EN to saturate instead of wrap.
module acc4_seq #(
  parameter int unsigned NUM = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
  input  logic       in_ci,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_sum,
  output logic       out_co
);

  localparam int unsigned DW = 4;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sticky_q, sticky_d;
  logic            beat;
  logic            last;
  logic [DW:0]     sum5;

  // Beats are refused while in reset and while a result is waiting.
  assign in_ready = ~rst & (state_q != DONE);
  assign beat     = in_valid & in_ready;
  assign sum5     = (DW+1)'(acc_q) + (DW+1)'(in_data) + (DW+1)'(in_ci);
  assign last     = (cnt_q == CW'(NUM - 1));

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    case (state_q)
      IDLE, ACC: begin
        if (beat) begin
          acc_d = sum5[DW-1:0];
`ifdef ACC4_SAT_EN
          if (sum5[DW] || sticky_q) acc_d = '1;
`endif
          sticky_d = sticky_q | sum5[DW];
          cnt_d    = cnt_q + CW'(1);
          state_d  = last ? DONE : ACC;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d  = IDLE;
          acc_d    = '0;
          cnt_d    = '0;
          sticky_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset discards any partial group.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end

  // Result outputs decode straight from flops and read zero when not valid.
  assign out_valid = (state_q == DONE);
  assign out_sum   = out_valid ? acc_q : '0;
  assign out_co    = out_valid & sticky_q;

endmodule

// File: tb/tb_acc4_seq.sv
// Scoreboard bench for acc4_seq: random and directed groups, reference model
// queue, monitor on the output handshake, plus a NUM=1 instance.
module tb_acc4_seq;

  localparam int NUM = 4;

  typedef struct {
    logic [3:0] sum;
    logic       co;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_data = '0;
  logic       in_ci = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] out_sum;
  logic       out_co;

  logic       b_in_valid = 1'b0;
  logic       b_in_ready;
  logic [3:0] b_in_data = '0;
  logic       b_in_ci = 1'b0;
  logic       b_out_valid;
  logic       b_out_ready = 1'b1;
  logic [3:0] b_out_sum;
  logic       b_out_co;

  int n_chk = 0;
  int n_fail = 0;
  int rdy_mode = 0;

  exp_t exp_q[$];
  int   m_acc = 0;
  int   m_co = 0;
  int   m_cnt = 0;

  acc4_seq #(.NUM(NUM)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ci(in_ci),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_co(out_co)
  );

  acc4_seq #(.NUM(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_ci(b_in_ci),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sum(b_out_sum), .out_co(b_out_co)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: group sum from plain integer arithmetic.
  task automatic model_beat(input int d, input int c);
    int t;
    exp_t e;
    t = m_acc + d + c;
    if (t > 15) m_co = 1;
    m_acc = t % 16;
`ifdef ACC4_SAT_EN
    if (m_co != 0) m_acc = 15;
`endif
    m_cnt++;
    if (m_cnt == NUM) begin
      e.sum = 4'(m_acc);
      e.co  = (m_co != 0);
      exp_q.push_back(e);
      m_acc = 0;
      m_co  = 0;
      m_cnt = 0;
    end
  endtask

  task automatic send_beat(input int d, input int c);
    int  n;
    bit  done_grp;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 4'(d);
    in_ci    = 1'(c);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("beat_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      done_grp = (m_cnt == NUM - 1);
      model_beat(d, c);
      @(posedge clk);
      #1 in_valid = 1'b0;
      if (done_grp) begin
        @(negedge clk);
        check("latency_out_valid", out_valid, 1);
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1 check("in_ready_during_rst", in_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    m_acc = 0;
    m_co  = 0;
    m_cnt = 0;
    @(negedge clk);
    check("in_ready_after_rst", in_ready, 1);
    check("out_valid_after_rst", out_valid, 0);
    check("out_sum_after_rst", out_sum, 0);
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: pops the scoreboard on each accepted result.
  bit         hold_prev = 0;
  bit         rel_prev = 0;
  logic [3:0] p_sum;
  logic       p_co;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold_prev = 0;
      rel_prev  = 0;
    end else begin
      if (rel_prev) begin
        check("idle_after_out_valid", out_valid, 0);
        check("idle_after_in_ready", in_ready, 1);
      end
      rel_prev = 0;
      if (!out_valid) begin
        check("zero_when_invalid", {out_sum, out_co}, 0);
        hold_prev = 0;
      end else begin
        check("in_ready_in_done", in_ready, 0);
        if (hold_prev) begin
          check("hold_sum", out_sum, p_sum);
          check("hold_co", out_co, p_co);
        end
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_result", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("out_sum", out_sum, e.sum);
            check("out_co", out_co, e.co);
          end
          rel_prev  = 1;
          hold_prev = 0;
        end else begin
          hold_prev = 1;
          p_sum     = out_sum;
          p_co      = out_co;
        end
      end
    end
  end

  initial begin
    int n;
    int exp1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready_low", in_ready, 0);
    check("reset_out_valid", out_valid, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_reset_in_ready", in_ready, 1);

    // 3,4,5,2 -> E
    send_beat(3, 0); send_beat(4, 0); send_beat(5, 0); send_beat(2, 0);
    idle_cycles(3);
    // F,1,0,0 -> carry set
    send_beat(15, 0); send_beat(1, 0); send_beat(0, 0); send_beat(0, 0);
    idle_cycles(3);
    // carry-ins only, spaced by idle cycles
    for (int i = 0; i < NUM; i++) begin
      send_beat(0, 1);
      idle_cycles(2);
    end
    idle_cycles(3);
    // back-pressure held for 3 cycles
    rdy_mode = 2;
    idle_cycles(1);
    send_beat(9, 1); send_beat(8, 0); send_beat(1, 1); send_beat(6, 0);
    repeat (3) @(negedge clk);
    check("stall_out_valid", out_valid, 1);
    rdy_mode = 0;
    idle_cycles(4);
    // partial group discarded by reset
    send_beat(7, 0); send_beat(7, 0);
    do_reset();
    send_beat(1, 0); send_beat(1, 0); send_beat(1, 0); send_beat(1, 0);
    idle_cycles(3);
    // random groups with random gaps and back-pressure
    rdy_mode = 1;
    for (int g = 0; g < 25; g++) begin
      for (int b = 0; b < NUM; b++) begin
        send_beat(int'($urandom_range(0, 15)), int'($urandom_range(0, 1)));
        idle_cycles(int'($urandom_range(0, 2)));
      end
    end
    rdy_mode = 0;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("scoreboard_drained", exp_q.size(), 0);

    // NUM=1 instance: each beat is a full group
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      b_in_valid = 1'b1;
      b_in_data  = (k == 0) ? 4'h9 : 4'hF;
      b_in_ci    = 1'b1;
      check("n1_in_ready", b_in_ready, 1);
      @(posedge clk);
      #1 b_in_valid = 1'b0;
      @(negedge clk);
      check("n1_out_valid", b_out_valid, 1);
      exp1 = (k == 0) ? 10 : 0;
`ifdef ACC4_SAT_EN
      if (k == 1) exp1 = 15;
`endif
      check("n1_out_sum", b_out_sum, exp1);
      check("n1_out_co", b_out_co, k);
      @(negedge clk);
      check("n1_back_idle", {b_out_valid, b_in_ready}, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/acc4_seq.md
ACC4_SEQ -- requirements
Module: acc4_seq

Interface
REQ-001 Parameter NUM, default 4: number of operand beats summed per group; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 in_valid  input  1  upstream beat present.
REQ-005 in_ready  output  1  block can accept a beat this cycle.
REQ-006 in_data  input  4  operand beat, unsigned.
REQ-007 in_ci  input  1  carry-in added with this beat.
REQ-008 out_valid  output  1  group result available.
REQ-009 out_ready  input  1  downstream accepts result.
REQ-010 out_sum  output  4  accumulated 4-bit sum.
REQ-011 out_co  output  1  sticky carry: set if any beat in the group produced carry-out.

Function
REQ-012 FSM states SHALL be IDLE, ACC, DONE; a beat is accepted when in_valid & in_ready.
REQ-013 IDLE: in_ready=1, out_valid=0, acc=0, count=0, sticky=0; first accepted beat moves to ACC, or to DONE if NUM=1.
REQ-014 Each accepted beat SHALL compute {c,s} = acc + in_data + in_ci (5-bit result), register acc<=s, sticky<=sticky|c, count<=count+1.
REQ-015 ACC: in_ready=1; cycles without in_valid SHALL leave acc, count, sticky unchanged.
REQ-016 Acceptance of the NUM-th beat SHALL move to DONE; out_valid SHALL assert the next cycle (latency 1 cycle from last beat).
REQ-017 DONE: in_ready=0, out_valid=1, out_sum=acc, out_co=sticky; values SHALL remain stable while out_ready=0.
REQ-018 DONE with out_ready=1 SHALL return to IDLE next cycle, clearing acc, count, sticky; no beat accepted in that cycle.
REQ-019 out_sum and out_co SHALL read 0 whenever out_valid=0.
REQ-020 Sum arithmetic SHALL wrap modulo 16 (default build, see REQ-025).
REQ-021 count width SHALL be 4 bits; no comparison beyond NUM.

Reset
REQ-022 rst=1 SHALL force IDLE, acc=0, count=0, sticky=0, in_ready=1 after the edge, out_valid=0, out_sum=0, out_co=0.
REQ-023 rst SHALL take priority over any simultaneous beat or output handshake; a partially accumulated group SHALL be discarded.
REQ-024 During rst=1, in_ready SHALL read 0 (no beat accepted).

Configuration
REQ-025 Macro ACC4_SAT_EN: when defined, a beat with c=1 SHALL set acc to 4'hF, and acc SHALL remain 4'hF for the rest of the group (sticky still set); when undefined, acc wraps per REQ-020.

Verification (NUM=4 unless noted)
REQ-026 Beats 3,4,5,2, ci=0, out_ready=1 -> out_valid 1 cycle after 4th beat, out_sum=4'hE, out_co=0, IDLE next cycle.
REQ-027 Beats F,1,0,0, ci=0 -> out_sum=0, out_co=1; with ACC4_SAT_EN -> out_sum=F, out_co=1.
REQ-028 Beats 0,0,0,0 each with ci=1, in_valid gaps of 2 cycles between beats -> out_sum=4, out_co=0.
REQ-029 Group complete, out_ready held 0 for 3 cycles -> out_valid, out_sum, out_co stable, in_ready=0; release -> IDLE, in_ready=1.
REQ-030 Two beats (7,7) accepted then rst pulse for 1 cycle, then beats 1,1,1,1 -> out_sum=4, out_co=0.
REQ-031 NUM=1, beat 9 with ci=1 -> out_sum=4'hA, out_co=0 one cycle later.
